// File: rtl/input_conditioner.sv
// input_conditioner: synchronise and debounce raw buttons and switches for the calculator datapath
//   clk        : system clock, rising edge
//   clr        : asynchronous active-low reset
//   btn_raw    : raw bouncing push buttons
//   sw_raw     : raw bouncing slide switches
//   btn_level  : debounced button level
//   btn_pulse  : one-cycle strobe per accepted press
//   sw_stable  : debounced switch word
//   sw_changed : one-cycle strobe when sw_stable updates
module input_conditioner #(
    parameter int N_BTN     = 2,
    parameter int SW_W      = 4,
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [SW_W-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [SW_W-1:0]  sw_stable,
    output logic             sw_changed
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} bstate_t;

    logic [N_BTN-1:0] b1, bs;
    logic [SW_W-1:0]  w1, ws, cand;
    logic [CNT_W-1:0] scnt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            b1 <= '0;
            bs <= '0;
            w1 <= '0;
            ws <= '0;
        end else begin
            b1 <= btn_raw;
            bs <= b1;
            w1 <= sw_raw;
            ws <= w1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < N_BTN; i++) begin : g_btn
            bstate_t          st, nst;
            logic [CNT_W-1:0] cnt, ncnt;
            logic             pulse, npulse;
            always_comb begin
                nst    = st;
                ncnt   = cnt;
                npulse = 1'b0;
                case (st)
                    IDLE: if (bs[i]) begin
                        nst  = PRESS_WAIT;
                        ncnt = '0;
                    end
                    PRESS_WAIT: if (!bs[i]) nst = IDLE;
                    else if (cnt == LAST) begin
                        nst    = HELD;
                        npulse = 1'b1;
                    end else ncnt = cnt + 1'b1;
                    HELD: if (!bs[i]) begin
                        nst  = RELEASE_WAIT;
                        ncnt = '0;
                    end
                    RELEASE_WAIT: if (bs[i]) nst = HELD;
                    else if (cnt == LAST) nst = IDLE;
                    else ncnt = cnt + 1'b1;
                    default: nst = IDLE;
                endcase
            end
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    st    <= IDLE;
                    cnt   <= '0;
                    pulse <= 1'b0;
                end else begin
                    st    <= nst;
                    cnt   <= ncnt;
                    pulse <= npulse;
                end
            end
            assign btn_level[i] = (st == HELD) || (st == RELEASE_WAIT);
            assign btn_pulse[i] = pulse;
        end
    endgenerate

    // One counter covers the whole word: any bit change restarts it, and it
    // saturates at LAST so a settled word that already matches stays quiet.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cand       <= '0;
            scnt       <= '0;
            sw_stable  <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= 1'b0;
            if (ws != cand) begin
                cand <= ws;
                scnt <= '0;
            end else begin
                scnt <= (scnt == LAST) ? scnt : scnt + 1'b1;
                if (scnt == LAST && cand != sw_stable) begin
                    sw_stable  <= cand;
                    sw_changed <= 1'b1;
                end
            end
        end
    end
endmodule
